// File: rtl/clk_reconfig_master_if.sv
// AXI4-Lite bus between the reconfiguration master and the clock manager's clking_axi slave port.
interface clk_reconfig_master_if;
  logic [10:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [10:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/clk_reconfig_master.sv
// Reprograms the clock manager over AXI4-Lite: four config writes, then status polling until lock.
// With a zero-wait slave, done_o is high in the cycle after clock edge 10+POLL_GAP counted from the accepting edge.
//
// state       | meaning
// S_IDLE      | waiting for req_i
// S_WR        | AW and W offered, each retired on its own ready
// S_WR_RESP   | waiting for B; advance write index or start polling
// S_POLL_WAIT | POLL_GAP idle cycles before the next status read
// S_RD_ADDR   | AR of status register offered
// S_RD_DATA   | waiting for R; check lock bit and poll budget
// S_DONE      | done_o pulse
// S_ERR       | err_o pulse
module clk_reconfig_master #(
  parameter int unsigned POLL_GAP  = 16,
  parameter int unsigned MAX_POLLS = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [7:0]            divclk_div_i,
  input  logic [7:0]            clkfb_mult_i,
  input  logic [7:0]            clkout0_div_i,
  input  logic [7:0]            clkout1_div_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  clk_reconfig_master_if.master m_axi
);

  localparam int unsigned GAP_W  = $clog2(POLL_GAP + 1);
  localparam int unsigned POLL_W = $clog2(MAX_POLLS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_POLL_WAIT, S_RD_ADDR, S_RD_DATA, S_DONE, S_ERR
  } state_t;

  state_t            state_q;
  logic [1:0]        idx_q;
  logic [7:0]        div_q, mult_q, out0_q, out1_q;
  logic              aw_done_q, w_done_q;
  logic [GAP_W-1:0]  gap_q;
  logic [POLL_W-1:0] polls_q;
  logic [10:0]       awaddr_q, araddr_q;
  logic [31:0]       wdata_q;
  logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic              busy_q, done_q, err_q;

  logic [1:0]        wr_idx_d;
  logic [10:0]       wr_addr_d;
  logic [31:0]       wr_data_d;
  logic [7:0]        div_s, mult_s, out0_s, out1_s;
  logic [POLL_W-1:0] polls_d;
  logic              aw_hs, w_hs, aw_fin, w_fin;

  assign aw_hs   = awvalid_q && m_axi.awready;
  assign w_hs    = wvalid_q && m_axi.wready;
  assign aw_fin  = aw_done_q || aw_hs;
  assign w_fin   = w_done_q || w_hs;
  assign polls_d = polls_q + POLL_W'(1);

  // In IDLE the first write is built straight from the inputs, since they are latched on the same edge.
  always_comb begin
    wr_idx_d  = idx_q + 2'd1;
    div_s     = div_q;
    mult_s    = mult_q;
    out0_s    = out0_q;
    out1_s    = out1_q;
    wr_addr_d = 11'h25C;
    wr_data_d = 32'h0000_0003;
    if (state_q == S_IDLE) begin
      wr_idx_d = 2'd0;
      div_s    = divclk_div_i;
      mult_s   = clkfb_mult_i;
      out0_s   = clkout0_div_i;
      out1_s   = clkout1_div_i;
    end
    case (wr_idx_d)
      2'd0: begin wr_addr_d = 11'h200; wr_data_d = {16'h0, mult_s, div_s}; end
      2'd1: begin wr_addr_d = 11'h208; wr_data_d = {24'h0, out0_s}; end
      2'd2: begin wr_addr_d = 11'h214; wr_data_d = {24'h0, out1_s}; end
      default: begin wr_addr_d = 11'h25C; wr_data_d = 32'h0000_0003; end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      div_q     <= '0;
      mult_q    <= '0;
      out0_q    <= '0;
      out1_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      gap_q     <= '0;
      polls_q   <= '0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            div_q     <= divclk_div_i;
            mult_q    <= clkfb_mult_i;
            out0_q    <= clkout0_div_i;
            out1_q    <= clkout1_div_i;
            idx_q     <= wr_idx_d;
            polls_q   <= '0;
            awaddr_q  <= wr_addr_d;
            wdata_q   <= wr_data_d;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_WR;
          end
        end
        S_WR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            if (m_axi.bresp != 2'b00) begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end else if (idx_q == 2'd3) begin
              gap_q   <= GAP_W'(POLL_GAP);
              state_q <= S_POLL_WAIT;
            end else begin
              idx_q     <= wr_idx_d;
              awaddr_q  <= wr_addr_d;
              wdata_q   <= wr_data_d;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= S_WR;
            end
          end
        end
        S_POLL_WAIT: begin
          if (gap_q == GAP_W'(1)) begin
            araddr_q  <= 11'h004;
            arvalid_q <= 1'b1;
            state_q   <= S_RD_ADDR;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        S_RD_ADDR: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi.rvalid) begin
            rready_q <= 1'b0;
            if (m_axi.rresp != 2'b00) begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end else if (m_axi.rdata[0]) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (polls_d == POLL_W'(MAX_POLLS)) begin
              err_q   <= 1'b1;
              state_q <= S_ERR;
            end else begin
              polls_q <= polls_d;
              gap_q   <= GAP_W'(POLL_GAP);
              state_q <= S_POLL_WAIT;
            end
          end
        end
        S_DONE, S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Only the lock flag of the status register matters here.
  logic unused_rdata;
  assign unused_rdata = ^m_axi.rdata[31:1];

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_clk_reconfig_master.sv
// Scoreboard bench for clk_reconfig_master: expected bus events are queued per sequence, a monitor pops and compares.
module tb_clk_reconfig_master;
  localparam int G  = 16;
  localparam int MP = 6;
  localparam int K_WR = 0, K_RD = 1, K_DONE = 2, K_ERR = 3;

  logic       clk = 1'b0;
  logic       rst, req;
  logic [7:0] div_v, mult_v, o0_v, o1_v;
  logic       busy, done, err;

  clk_reconfig_master_if axi ();

  clk_reconfig_master #(.POLL_GAP(G), .MAX_POLLS(MP)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .divclk_div_i (div_v),
    .clkfb_mult_i (mult_v),
    .clkout0_div_i(o0_v),
    .clkout1_div_i(o1_v),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .m_axi        (axi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_bad = 0;
  int done_cyc = 0;

  // slave configuration and state
  int aw_dly = 0, w_dly = 0, b_rand = 0, r_rand = 0;
  int b_err_idx = -1, r_err_idx = -1, lock_at = 0;
  int wr_count = 0, rd_count = 0;
  int aw_cnt, w_cnt, b_cnt, r_cnt;
  bit s_aw, s_w, b_arm, r_arm, b_hs, r_hs;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  function automatic void exp_ev(input int kind, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endfunction

  function automatic void pop_chk(input int kind, input logic [31:0] addr, input logic [31:0] data,
                                  input bit cmp_data);
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d addr %h, expected no event", kind, addr);
      return;
    end
    e = sb.pop_front();
    chk("event_kind", 32'(kind), 32'(e.kind));
    chk("event_addr", addr, e.addr);
    if (cmp_data) chk("event_data", data, e.data);
  endfunction

  // AXI slave model: drives at negedge+1, handshakes take effect at the following posedge
  initial begin : slave
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
    s_aw = 0; s_w = 0; b_arm = 0; r_arm = 0; b_hs = 0; r_hs = 0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
        aw_cnt = 0; w_cnt = 0; s_aw = 0; s_w = 0; b_arm = 0; r_arm = 0; b_hs = 0; r_hs = 0;
        continue;
      end
      if (axi.bvalid && b_hs) axi.bvalid = 1'b0;
      if (b_arm) begin
        if (b_cnt == 0) begin
          axi.bvalid = 1'b1;
          axi.bresp  = ((wr_count - 1) == b_err_idx) ? 2'b10 : 2'b00;
          b_arm = 0;
        end else b_cnt--;
      end
      b_hs = axi.bvalid && axi.bready;
      if (axi.rvalid && r_hs) axi.rvalid = 1'b0;
      if (r_arm) begin
        if (r_cnt == 0) begin
          axi.rvalid = 1'b1;
          axi.rresp  = ((rd_count - 1) == r_err_idx) ? 2'b10 : 2'b00;
          axi.rdata  = {31'h2AF0_1234, ((rd_count - 1) >= lock_at)};
          r_arm = 0;
        end else r_cnt--;
      end
      r_hs = axi.rvalid && axi.rready;
      if (aw_dly == 0) axi.awready = 1'b1;
      else if (axi.awready) axi.awready = 1'b0;
      else if (axi.awvalid) begin
        if (aw_cnt == aw_dly) begin axi.awready = 1'b1; aw_cnt = 0; end
        else aw_cnt++;
      end
      if (w_dly == 0) axi.wready = 1'b1;
      else if (axi.wready) axi.wready = 1'b0;
      else if (axi.wvalid) begin
        if (w_cnt == w_dly) begin axi.wready = 1'b1; w_cnt = 0; end
        else w_cnt++;
      end
      if (axi.awvalid && axi.awready) s_aw = 1;
      if (axi.wvalid && axi.wready) s_w = 1;
      if (s_aw && s_w) begin
        s_aw = 0; s_w = 0;
        wr_count++;
        b_arm = 1;
        b_cnt = (b_rand != 0) ? int'($urandom_range(0, 5)) : 0;
      end
      axi.arready = 1'b1;
      if (axi.arvalid && axi.arready) begin
        rd_count++;
        r_arm = 1;
        r_cnt = (r_rand != 0) ? int'($urandom_range(0, 5)) : 0;
      end
    end
  end

  // monitor: protocol hold checks and scoreboard pops, sampled after the slave has settled
  initial begin : monitor
    bit          p_awv, p_aw_hs, p_wv, p_w_hs, p_arv, p_ar_hs, p_pulse, g_aw, g_w, ar_seen;
    logic [10:0] p_awaddr, p_araddr, c_awaddr;
    logic [31:0] p_wdata, c_wdata;
    int          ar_idle;
    p_awv = 0; p_aw_hs = 0; p_wv = 0; p_w_hs = 0; p_arv = 0; p_ar_hs = 0; p_pulse = 0;
    g_aw = 0; g_w = 0; ar_seen = 0; ar_idle = 0;
    p_awaddr = '0; p_araddr = '0; c_awaddr = '0; p_wdata = '0; c_wdata = '0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        p_awv = 0; p_wv = 0; p_arv = 0; p_pulse = 0; g_aw = 0; g_w = 0; ar_seen = 0;
        continue;
      end
      if (p_awv && !p_aw_hs) chk("aw_hold", 32'({axi.awvalid, axi.awaddr}), 32'({1'b1, p_awaddr}));
      if (p_wv && !p_w_hs) begin
        chk("w_hold_valid", 32'(axi.wvalid), 32'd1);
        chk("w_hold_data", axi.wdata, p_wdata);
      end
      if (p_arv && !p_ar_hs) chk("ar_hold", 32'({axi.arvalid, axi.araddr}), 32'({1'b1, p_araddr}));
      if (axi.awvalid && axi.awready) begin g_aw = 1; c_awaddr = axi.awaddr; end
      if (axi.wvalid && axi.wready) begin
        g_w = 1;
        c_wdata = axi.wdata;
        chk("wstrb", 32'(axi.wstrb), 32'hF);
      end
      if (g_aw && g_w) begin
        pop_chk(K_WR, 32'(c_awaddr), c_wdata, 1'b1);
        g_aw = 0; g_w = 0;
      end
      if (axi.arvalid && axi.arready) begin
        if (ar_seen) chk("ar_gap_min", (ar_idle >= G) ? 32'd1 : 32'd0, 32'd1);
        pop_chk(K_RD, 32'(axi.araddr), 32'd0, 1'b0);
        ar_seen = 1;
        ar_idle = 0;
      end else if (!axi.arvalid) ar_idle++;
      if (p_pulse) chk("after_pulse_idle", 32'({busy, done, err}), 32'd0);
      if (done) begin
        pop_chk(K_DONE, 32'd0, 32'd0, 1'b0);
        chk("done_while_busy", 32'(busy), 32'd1);
        done_cyc = cyc;
      end
      if (err) pop_chk(K_ERR, 32'd0, 32'd0, 1'b0);
      if (done || err) ar_seen = 0;
      p_pulse  = done | err;
      p_awv    = axi.awvalid; p_aw_hs = axi.awvalid && axi.awready; p_awaddr = axi.awaddr;
      p_wv     = axi.wvalid;  p_w_hs  = axi.wvalid && axi.wready;   p_wdata  = axi.wdata;
      p_arv    = axi.arvalid; p_ar_hs = axi.arvalid && axi.arready; p_araddr = axi.araddr;
    end
  end

  task automatic start(input logic [7:0] d, input logic [7:0] m, input logic [7:0] a,
                       input logic [7:0] b, output int t0);
    wr_count = 0;
    rd_count = 0;
    @(negedge clk);
    div_v = d; mult_v = m; o0_v = a; o1_v = b;
    req = 1'b1;
    t0 = cyc;
    @(negedge clk);
    req = 1'b0;
    div_v = ~d; mult_v = ~m; o0_v = ~a; o1_v = ~b;
    chk("busy_awv_wv_rise", 32'({busy, axi.awvalid, axi.wvalid}), 32'h7);
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_all_events_seen"}, 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (30) @(negedge clk);
    chk({nm, "_quiet_after"}, 32'({busy, axi.awvalid, axi.wvalid, axi.arvalid}), 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, 32'({busy, done, err, axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 32'd0);
    chk({nm, "_addr"}, 32'({axi.awaddr, axi.araddr}), 32'd0);
    chk({nm, "_wdata"}, axi.wdata, 32'd0);
  endtask

  task automatic push_nominal();
    exp_ev(K_WR, 32'h200, 32'h0000_0A01);
    exp_ev(K_WR, 32'h208, 32'h0000_0014);
    exp_ev(K_WR, 32'h214, 32'h0000_0014);
    exp_ev(K_WR, 32'h25C, 32'h0000_0003);
    exp_ev(K_RD, 32'h004, 32'd0);
    exp_ev(K_DONE, 32'd0, 32'd0);
  endtask

  initial begin : stim
    int t0;
    rst = 1'b1; req = 1'b0;
    div_v = '0; mult_v = '0; o0_v = '0; o1_v = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // nominal, zero-wait, lock on first read; a second req mid-sequence must be ignored
    push_nominal();
    start(8'd1, 8'd10, 8'd20, 8'd20, t0);
    repeat (5) @(negedge clk);
    req = 1'b1; div_v = 8'h55; mult_v = 8'h66;
    @(negedge clk);
    req = 1'b0;
    drain("nominal", 300);
    chk("nominal_latency", 32'(done_cyc - t0), 32'(8 + G + 3));

    // backpressure: AW delayed 3, W ready at once, random B/R delays
    aw_dly = 3; w_dly = 0; b_rand = 1; r_rand = 1;
    exp_ev(K_WR, 32'h200, 32'h0000_2402);
    exp_ev(K_WR, 32'h208, 32'h0000_0008);
    exp_ev(K_WR, 32'h214, 32'h0000_0010);
    exp_ev(K_WR, 32'h25C, 32'h0000_0003);
    exp_ev(K_RD, 32'h004, 32'd0);
    exp_ev(K_DONE, 32'd0, 32'd0);
    start(8'd2, 8'h24, 8'd8, 8'h10, t0);
    drain("backpressure", 400);
    aw_dly = 0; b_rand = 0; r_rand = 0;

    // slow lock: five unlocked reads then lock on the last allowed poll
    lock_at = 5;
    exp_ev(K_WR, 32'h200, 32'h0000_3004);
    exp_ev(K_WR, 32'h208, 32'h0000_0006);
    exp_ev(K_WR, 32'h214, 32'h0000_000C);
    exp_ev(K_WR, 32'h25C, 32'h0000_0003);
    for (int i = 0; i < 6; i++) exp_ev(K_RD, 32'h004, 32'd0);
    exp_ev(K_DONE, 32'd0, 32'd0);
    start(8'd4, 8'h30, 8'd6, 8'd12, t0);
    drain("slow_lock", 600);

    // timeout: never locks, exactly MAX_POLLS reads then err
    lock_at = 1000;
    exp_ev(K_WR, 32'h200, 32'h0000_0801);
    exp_ev(K_WR, 32'h208, 32'h0000_00FF);
    exp_ev(K_WR, 32'h214, 32'h0000_0080);
    exp_ev(K_WR, 32'h25C, 32'h0000_0003);
    for (int i = 0; i < 6; i++) exp_ev(K_RD, 32'h004, 32'd0);
    exp_ev(K_ERR, 32'd0, 32'd0);
    start(8'd1, 8'h08, 8'hFF, 8'h80, t0);
    drain("timeout", 600);
    lock_at = 0;

    // SLVERR on write index 1, W delayed so AW and W complete on different cycles
    b_err_idx = 1; w_dly = 2;
    exp_ev(K_WR, 32'h200, 32'h0000_1103);
    exp_ev(K_WR, 32'h208, 32'h0000_0022);
    exp_ev(K_ERR, 32'd0, 32'd0);
    start(8'd3, 8'h11, 8'h22, 8'h33, t0);
    drain("bresp_err", 300);
    b_err_idx = -1; w_dly = 0;

    // SLVERR on the first status read even though the lock bit is set
    r_err_idx = 0;
    exp_ev(K_WR, 32'h200, 32'h0000_0501);
    exp_ev(K_WR, 32'h208, 32'h0000_000A);
    exp_ev(K_WR, 32'h214, 32'h0000_000B);
    exp_ev(K_WR, 32'h25C, 32'h0000_0003);
    exp_ev(K_RD, 32'h004, 32'd0);
    exp_ev(K_ERR, 32'd0, 32'd0);
    start(8'd1, 8'h05, 8'h0A, 8'h0B, t0);
    drain("rresp_err", 300);
    r_err_idx = -1;

    // reset while AW is stalled: abort with no pulse, then a clean sequence
    aw_dly = 5;
    start(8'd9, 8'd9, 8'd9, 8'd9, t0);
    @(negedge clk);
    chk("rst_pre_awvalid", 32'(axi.awvalid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_abort");
    rst = 1'b0;
    aw_dly = 0;
    repeat (40) @(negedge clk);
    chk("rst_no_restart", 32'({busy, done, err, axi.awvalid}), 32'd0);
    push_nominal();
    start(8'd1, 8'd10, 8'd20, 8'd20, t0);
    drain("after_reset", 300);
    chk("after_reset_latency", 32'(done_cyc - t0), 32'(8 + G + 3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
